// File: rtl/mmio_pkg.sv
// Shared address map, status bit positions and access decode for the MMIO responder.
package mmio_pkg;

    localparam logic [3:0] MMIO_BASE_NIBBLE = 4'h8;

    localparam logic [7:0] OFF_STATUS  = 8'h00;
    localparam logic [7:0] OFF_RX      = 8'h04;
    localparam logic [7:0] OFF_TX      = 8'h08;
    localparam logic [7:0] OFF_CYC     = 8'h10;
    localparam logic [7:0] OFF_INST    = 8'h14;
    localparam logic [7:0] OFF_CNT_CLR = 8'h18;

    localparam int unsigned ST_TX_NOTFULL  = 0;
    localparam int unsigned ST_RX_NONEMPTY = 1;
    localparam int unsigned ST_OVF         = 2;

    typedef enum logic [1:0] {
        ACC_NONE  = 2'd0,
        ACC_LOAD  = 2'd1,
        ACC_STORE = 2'd2
    } acc_e;

    // Classify a CPU access: only the top nibble selects this target.
    function automatic acc_e decode_access(input logic       valid,
                                           input logic [3:0] addr_hi,
                                           input logic [3:0] wmask);
        if (!valid || addr_hi != MMIO_BASE_NIBBLE) return ACC_NONE;
        return (wmask == 4'h0) ? ACC_LOAD : ACC_STORE;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; a pop frees space for a push in the same cycle when full.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = i_pop && !w_empty;
    assign w_do_push = i_push && (!w_full || w_do_pop);

    assign o_empty = w_empty;
    assign o_full  = w_full;
    // Empty reads as zero so the head never exposes stale storage.
    assign o_dout  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];

    // Pointer update; extra MSB distinguishes full from empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
            if (w_do_pop)  r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/mmio_responder.sv
// MMIO target at 0x8xxx_xx00..FF: UART RX/TX FIFOs, status, cycle and instret counters.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = 32
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    input  logic [3:0]  i_req_wmask,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic [31:0] o_rdata,
    input  logic        i_inst_retire,
    input  logic [7:0]  i_uart_rx_data,
    input  logic        i_uart_rx_valid,
    output logic        o_uart_rx_ready,
    output logic [7:0]  o_uart_tx_data,
    output logic        o_uart_tx_valid,
    input  logic        i_uart_tx_ready
);

    acc_e        w_acc;
    logic [7:0]  w_off;
    logic        w_load;
    logic        w_store;

    logic        w_rx_push, w_rx_pop, w_rx_full, w_rx_empty;
    logic [7:0]  w_rx_head;
    logic        w_tx_push, w_tx_pop, w_tx_full, w_tx_empty;
    logic        w_cnt_clr;
    logic [31:0] w_rd_mux;
    logic [31:0] w_status;
    logic        w_unused;

    logic [CNT_W-1:0] r_cyc;
    logic [CNT_W-1:0] r_inst;
    logic             r_ovf;
    logic [31:0]      r_rdata;

    assign w_acc   = decode_access(i_req_valid, i_req_addr[31:28], i_req_wmask);
    assign w_off   = i_req_addr[7:0];
    assign w_load  = (w_acc == ACC_LOAD);
    assign w_store = (w_acc == ACC_STORE);
    assign w_unused = ^{i_req_addr[27:8], i_req_wdata[31:8]};

    assign w_rx_push = i_uart_rx_valid && !w_rx_full;
    assign w_rx_pop  = w_load && (w_off == OFF_RX);
    assign w_tx_push = w_store && (w_off == OFF_TX) && i_req_wmask[0];
    assign w_tx_pop  = !w_tx_empty && i_uart_tx_ready;
    assign w_cnt_clr = w_store && (w_off == OFF_CNT_CLR);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_rx_push),
        .i_pop   (w_rx_pop),
        .i_din   (i_uart_rx_data),
        .o_dout  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_tx_push),
        .i_pop   (w_tx_pop),
        .i_din   (i_req_wdata[7:0]),
        .o_dout  (o_uart_tx_data),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    assign o_uart_rx_ready = !w_rx_full;
    assign o_uart_tx_valid = !w_tx_empty;
    assign o_rdata         = r_rdata;

    // Read data selection from pre-edge state.
    always_comb begin
        w_status                 = '0;
        w_status[ST_TX_NOTFULL]  = !w_tx_full;
        w_status[ST_RX_NONEMPTY] = !w_rx_empty;
        w_status[ST_OVF]         = r_ovf;
        w_rd_mux                 = '0;
        case (w_off)
            OFF_STATUS: w_rd_mux = w_status;
            OFF_RX:     w_rd_mux = {24'h0, w_rx_head};
            OFF_CYC:    w_rd_mux = 32'(r_cyc);
            OFF_INST:   w_rd_mux = 32'(r_inst);
            default:    w_rd_mux = '0;
        endcase
    end

    // Registered load data; held until the next selected load.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)    r_rdata <= '0;
        else if (w_load) r_rdata <= w_rd_mux;
    end

    // Sticky overflow: set only when a TX push is actually dropped.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_store && (w_off == OFF_STATUS)) begin
            r_ovf <= 1'b0;
        end else if (w_tx_push && w_tx_full && !w_tx_pop) begin
            r_ovf <= 1'b1;
        end
    end

    // Free-running counters; clear takes priority over increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cyc  <= '0;
            r_inst <= '0;
        end else if (w_cnt_clr) begin
            r_cyc  <= '0;
            r_inst <= '0;
        end else begin
            r_cyc <= r_cyc + {{(CNT_W-1){1'b0}}, 1'b1};
            if (i_inst_retire) r_inst <= r_inst + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Scoreboarded bench for mmio_responder: load results are queued at issue and checked one cycle later.
module tb_mmio_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic [3:0]  req_wmask = 4'h0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] rdata;
    logic        inst_retire = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    logic [31:0] expq [$];
    string       tagq [$];

    mmio_responder #(.FIFO_DEPTH(8), .CNT_W(32)) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_req_valid     (req_valid),
        .i_req_wmask     (req_wmask),
        .i_req_addr      (req_addr),
        .i_req_wdata     (req_wdata),
        .o_rdata         (rdata),
        .i_inst_retire   (inst_retire),
        .i_uart_rx_data  (rx_data),
        .i_uart_rx_valid (rx_valid),
        .o_uart_rx_ready (rx_ready),
        .o_uart_tx_data  (tx_data),
        .o_uart_tx_valid (tx_valid),
        .i_uart_tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        req_wmask = 4'h0;
    endtask

    task automatic ld(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        @(negedge clk);
        req_valid = 1'b1;
        req_wmask = 4'h0;
        req_addr  = addr;
        expq.push_back(exp);
        tagq.push_back(tag);
    endtask

    task automatic st(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        req_valid = 1'b1;
        req_wmask = mask;
        req_addr  = addr;
        req_wdata = data;
    endtask

    // Compare each sampled load one step after the edge that captured it.
    always @(posedge clk) begin
        if (rst_n && req_valid && req_addr[31:28] == 4'h8 && req_wmask == 4'h0) begin
            #1;
            if (expq.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                check(tagq.pop_front(), rdata, expq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values while held in reset.
        #12;
        check("rst_rdata",    rdata,           32'h0);
        check("rst_rx_ready", 32'(rx_ready),   32'h1);
        check("rst_tx_valid", 32'(tx_valid),   32'h0);
        check("rst_tx_data",  32'(tx_data),    32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        ld(32'h8000_0010, 32'd5,   "cyc_after_reset");
        ld(32'h8000_0000, 32'h1,   "status_idle");
        idle();
        check("tx_valid_idle", 32'(tx_valid), 32'h0);

        // RX path: two bytes, drain, pop on empty.
        @(negedge clk); rx_valid = 1'b1; rx_data = 8'h41;
        @(negedge clk); rx_data = 8'h42;
        ld(32'h8000_0000, 32'h3, "status_rx2");
        rx_valid = 1'b0;
        ld(32'h8000_0004, 32'h41, "rx_pop0");
        ld(32'h8abc_de04, 32'h42, "rx_pop1_alias");
        ld(32'h8000_0004, 32'h00, "rx_pop_empty");
        ld(32'h8000_0000, 32'h1,  "status_rx0");
        ld(32'h8000_000C, 32'h0,  "unmapped_read");
        idle();

        // TX path: fill past capacity with the transmitter stalled.
        tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) st(32'h8000_0008, 32'hABCD_EF00 | 32'(i), 4'h1);
        ld(32'h8000_0000, 32'h4, "status_tx_ovf");
        idle();
        check("tx_valid_full", 32'(tx_valid), 32'h1);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("tx_byte%0d", i), 32'(tx_data), 32'(i));
            @(negedge clk);
        end
        check("tx_valid_drained", 32'(tx_valid), 32'h0);
        st(32'h8000_0000, 32'h0, 4'hF);
        ld(32'h8000_0000, 32'h1, "status_ovf_cleared");
        idle();

        // RX full back-pressure and the ninth byte after one pop.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); rx_valid = 1'b1; rx_data = 8'h50 + 8'(i);
        end
        @(negedge clk);
        rx_data = 8'h58;
        check("rx_ready_full", 32'(rx_ready), 32'h0);
        ld(32'h8000_0004, 32'h50, "rx_full_pop");
        idle();
        check("rx_ready_after_pop", 32'(rx_ready), 32'h1);
        @(negedge clk);
        rx_valid = 1'b0;
        check("rx_ready_refull", 32'(rx_ready), 32'h0);
        for (int i = 1; i < 9; i++) ld(32'h8000_0004, 32'h50 + 32'(i), $sformatf("rx_drain%0d", i));
        idle();

        // Counters: retire on 3 of 10 cycles, then clear while retiring.
        st(32'h8000_0018, 32'h0, 4'hF);
        for (int i = 0; i < 10; i++) begin
            idle();
            inst_retire = (i == 1 || i == 4 || i == 8);
        end
        ld(32'h8000_0014, 32'd3,  "instret_3");
        inst_retire = 1'b0;
        ld(32'h8000_0010, 32'd11, "cyc_11");
        st(32'h8000_0018, 32'h0, 4'h1);
        inst_retire = 1'b1;
        ld(32'h8000_0010, 32'd0,  "cyc_cleared");
        inst_retire = 1'b0;
        ld(32'h8000_0014, 32'd0,  "instret_cleared");
        idle();
        inst_retire = 1'b1;
        ld(32'h8000_0014, 32'd1,  "instret_resume");
        inst_retire = 1'b0;
        ld(32'h8000_0010, 32'd4,  "cyc_resume");
        idle();

        // Asynchronous reset with both FIFOs partly filled.
        tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            st(32'h8000_0008, 32'(8'hA0 + 8'(i)), 4'h1);
            rx_valid = 1'b1; rx_data = 8'hC0 + 8'(i);
        end
        idle();
        rx_valid = 1'b0;
        check("pre_rst_tx_valid", 32'(tx_valid), 32'h1);
        check("pre_rst_tx_data",  32'(tx_data),  32'hA0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rdata",    rdata,         32'h0);
        check("mid_rst_rx_ready", 32'(rx_ready), 32'h1);
        check("mid_rst_tx_valid", 32'(tx_valid), 32'h0);
        check("mid_rst_tx_data",  32'(tx_data),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ld(32'h8000_0000, 32'h1, "status_after_rst");
        ld(32'h8000_0004, 32'h0, "rx_empty_after_rst");
        idle();
        @(posedge clk);
        #2;
        check("sb_leftover", 32'(expq.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
